// File: rtl/shifter_r32_pipe_if.sv
// Handshake bundle for the pipelined RV32 right shifter.
// Issue side:     flush, in_valid/in_ready, in_arith, in_shamt, in_data, in_tag.
// Writeback side: out_valid/out_ready, out_data, out_tag.
// master: the issue/writeback agent driving operations and consuming results.
// slave:  the shifter itself.
interface shifter_r32_pipe_if #(
   parameter int unsigned TAG_W = 5
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic             in_arith;
   logic [4:0]       in_shamt;
   logic [31:0]      in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output flush, in_valid, in_arith, in_shamt, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  flush, in_valid, in_arith, in_shamt, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/shifter_r32_pipe.sv
// Two-stage pipelined 32-bit right shifter (SRL/SRLI zero fill, SRA/SRAI sign fill).
// Stage 1 does the byte-granular part of the shift, stage 2 the remaining 0-7 bits.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of shifter_r32_pipe_if (issue handshake, flush, result handshake)
module shifter_r32_pipe #(
   parameter int unsigned TAG_W = 5
) (
   input logic               clk,
   input logic               rst_n,
   shifter_r32_pipe_if.slave bus
);

   logic             s1_valid;
   logic [31:0]      s1_data;
   logic [2:0]       s1_fine;
   logic             s1_fill;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   logic [31:0]      s2_data;
   logic [TAG_W-1:0] s2_tag;

   logic             s2_advance_ok;
   logic             s1_advance;
   logic             accept;
   logic             in_fill;
   logic [31:0]      coarse;
   logic [31:0]      fine;

   // Backpressure chain depends only on pipeline state and out_ready, never on in_valid.
   assign s2_advance_ok = !s2_valid | bus.out_ready;
   assign s1_advance    = s1_valid & s2_advance_ok;
   assign bus.in_ready  = !s1_valid | s2_advance_ok;
   assign accept        = bus.in_valid & bus.in_ready;

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_tag   = s2_tag;

   assign in_fill = bus.in_arith & bus.in_data[31];

   // Byte-granular shift by 8 * shamt[4:3].
   always_comb begin
      coarse = bus.in_data;
      unique case (bus.in_shamt[4:3])
         2'd0: coarse = bus.in_data;
         2'd1: coarse = {{8{in_fill}},  bus.in_data[31:8]};
         2'd2: coarse = {{16{in_fill}}, bus.in_data[31:16]};
         2'd3: coarse = {{24{in_fill}}, bus.in_data[31:24]};
         default: coarse = bus.in_data;
      endcase
   end

   // Residual 0-7 bit shift using the fill bit captured in stage 1.
   always_comb begin
      fine = s1_data;
      unique case (s1_fine)
         3'd0: fine = s1_data;
         3'd1: fine = {{1{s1_fill}}, s1_data[31:1]};
         3'd2: fine = {{2{s1_fill}}, s1_data[31:2]};
         3'd3: fine = {{3{s1_fill}}, s1_data[31:3]};
         3'd4: fine = {{4{s1_fill}}, s1_data[31:4]};
         3'd5: fine = {{5{s1_fill}}, s1_data[31:5]};
         3'd6: fine = {{6{s1_fill}}, s1_data[31:6]};
         3'd7: fine = {{7{s1_fill}}, s1_data[31:7]};
         default: fine = s1_data;
      endcase
   end

   // Valid bits: flush wins over any accept or advance in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (bus.flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
         end else if (s1_advance) begin
            s1_valid <= 1'b0;
         end

         if (s1_advance) begin
            s2_valid <= 1'b1;
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   // Data registers load on their enables even during flush; the cleared valids
   // make any stale contents invisible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data <= '0;
         s1_fine <= '0;
         s1_fill <= 1'b0;
         s1_tag  <= '0;
         s2_data <= '0;
         s2_tag  <= '0;
      end else begin
         if (accept) begin
            s1_data <= coarse;
            s1_fine <= bus.in_shamt[2:0];
            s1_fill <= in_fill;
            s1_tag  <= bus.in_tag;
         end
         if (s1_advance) begin
            s2_data <= fine;
            s2_tag  <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_shifter_r32_pipe.sv
// Self-checking bench for shifter_r32_pipe: directed scenarios plus a randomized
// run checked against an arithmetic reference and an in-flight queue model.
module tb_shifter_r32_pipe;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   shifter_r32_pipe_if #(.TAG_W(5)) bus ();

   shifter_r32_pipe #(.TAG_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  tag;
   } result_t;

   function automatic logic [31:0] ref_shift(input logic arith, input logic [4:0] sh,
                                             input logic [31:0] d);
      logic signed [31:0] sd;
      logic signed [31:0] sr;
      logic [31:0]        r;
      sd = d;
      if (arith) begin
         sr = sd >>> sh;
         r  = sr;
      end else begin
         r = d >> sh;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_arith  = 1'b0;
      bus.in_shamt  = '0;
      bus.in_data   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
   endtask

   // Issues one op with out_ready high; lat = edges from accept to out_valid, -1 on timeout.
   task automatic run_op(input logic arith, input logic [4:0] sh, input logic [31:0] d,
                         input logic [4:0] tag, output logic [31:0] rd, output logic [4:0] rt,
                         output int lat);
      int w;
      rd = '0;
      rt = '0;
      lat = -1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_arith  = arith;
      bus.in_shamt  = sh;
      bus.in_data   = d;
      bus.in_tag    = tag;
      #1;
      w = 0;
      while (!bus.in_ready && w < 20) begin
         tick();
         w++;
      end
      tick();
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (bus.out_valid) begin
            rd  = bus.out_data;
            rt  = bus.out_tag;
            lat = c;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 5'h0) begin
         failures++;
         $display("FAIL reset_outputs got valid=%b data=%h tag=%h want 0/0/0",
                  bus.out_valid, bus.out_data, bus.out_tag);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
      tick();
   endtask

   task automatic test_smoke();
      logic [31:0] rd;
      logic [4:0]  rt;
      int          lat;
      run_op(1'b0, 5'd4, 32'hF000_0000, 5'd5, rd, rt, lat);
      checks++;
      if (rd !== 32'h0F00_0000 || rt !== 5'd5 || lat != 2) begin
         failures++;
         $display("FAIL srl_smoke got data=%h tag=%0d lat=%0d want 0f000000/5/2", rd, rt, lat);
      end
   endtask

   task automatic test_sign_fill();
      logic [31:0] rd;
      logic [4:0]  rt;
      int          lat;
      run_op(1'b1, 5'd31, 32'h8000_0000, 5'd1, rd, rt, lat);
      checks++;
      if (rd !== 32'hFFFF_FFFF || lat != 2) begin
         failures++;
         $display("FAIL sra_neg31 got=%h lat=%0d want ffffffff/2", rd, lat);
      end
      run_op(1'b0, 5'd31, 32'h8000_0000, 5'd2, rd, rt, lat);
      checks++;
      if (rd !== 32'h0000_0001) begin
         failures++;
         $display("FAIL srl_neg31 got=%h want 00000001", rd);
      end
      run_op(1'b1, 5'd31, 32'h7FFF_FFFF, 5'd3, rd, rt, lat);
      checks++;
      if (rd !== 32'h0000_0000) begin
         failures++;
         $display("FAIL sra_pos31 got=%h want 00000000", rd);
      end
      run_op(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd4, rd, rt, lat);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL sra_shamt0 got=%h want deadbeef", rd);
      end
      run_op(1'b1, 5'd13, 32'h1234_5678, 5'd6, rd, rt, lat);
      checks++;
      if (rd !== 32'h0000_91A2) begin
         failures++;
         $display("FAIL sra_positive_eq_srl got=%h want 000091a2", rd);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] rd;
      logic [4:0]  rt;
      logic [31:0] neg;
      int          lat;
      for (int s = 0; s < 32; s++) begin
         run_op(1'b0, 5'(s), 32'h1234_5678, 5'(s), rd, rt, lat);
         checks++;
         if (rd !== (32'h1234_5678 >> s) || rt !== 5'(s) || lat != 2) begin
            failures++;
            $display("FAIL srl_sweep shamt=%0d got=%h tag=%0d lat=%0d want %h", s, rd, rt, lat,
                     32'h1234_5678 >> s);
         end
      end
      for (int s = 0; s < 32; s++) begin
         neg = $urandom | 32'h8000_0000;
         run_op(1'b1, 5'(s), neg, 5'(31 - s), rd, rt, lat);
         checks++;
         if (rd !== ref_shift(1'b1, 5'(s), neg) || rt !== 5'(31 - s)) begin
            failures++;
            $display("FAIL sra_sweep shamt=%0d in=%h got=%h want %h", s, neg, rd,
                     ref_shift(1'b1, 5'(s), neg));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      logic [4:0]  sh [4];
      logic        ar [4];
      logic [31:0] exp_d [4];
      int          idx;
      int          nout;
      for (int i = 0; i < 4; i++) begin
         d[i]     = $urandom;
         sh[i]    = 5'($urandom_range(0, 31));
         ar[i]    = 1'($urandom);
         exp_d[i] = ref_shift(ar[i], sh[i], d[i]);
      end
      idx  = 0;
      nout = 0;
      for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
         bus.in_valid  = (idx < 4);
         if (idx < 4) begin
            bus.in_data  = d[idx];
            bus.in_shamt = sh[idx];
            bus.in_arith = ar[idx];
            bus.in_tag   = 5'(10 + idx);
         end
         bus.out_ready = (cyc >= 6);
         #1;
         if (cyc >= 2 && cyc < 6) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               failures++;
               $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[0] || bus.out_tag !== 5'd10) begin
               failures++;
               $display("FAIL stall_hold cyc=%0d got v=%b d=%h t=%0d want 1/%h/10", cyc,
                        bus.out_valid, bus.out_data, bus.out_tag, exp_d[0]);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (bus.out_data !== exp_d[nout] || bus.out_tag !== 5'(10 + nout)) begin
               failures++;
               $display("FAIL stream_order n=%0d got=%h/%0d want %h/%0d", nout, bus.out_data,
                        bus.out_tag, exp_d[nout], 10 + nout);
            end
            nout++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (nout != 4 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_count got=%0d extra_valid=%b want 4/0", nout, bus.out_valid);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [31:0] rd;
      logic [4:0]  rt;
      int          lat;
      logic        seen;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hAAAA_5555;
      bus.in_shamt  = 5'd3;
      bus.in_tag    = 5'd20;
      tick();
      bus.in_tag    = 5'd21;
      tick();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b1;
      tick();
      bus.flush     = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_clears got out_valid=%b want 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_in_ready got=%b want 1", bus.in_ready);
      end
      tick();
      // An accept coinciding with flush must vanish.
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (bus.out_valid) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL flush_discard got out_valid=1 want 0");
      end
      run_op(1'b1, 5'd8, 32'hFFFF_0000, 5'd9, rd, rt, lat);
      checks++;
      if (rd !== 32'hFFFF_FF00 || rt !== 5'd9 || lat != 2) begin
         failures++;
         $display("FAIL post_flush_op got=%h tag=%0d lat=%0d want ffffff00/9/2", rd, rt, lat);
      end
   endtask

   task automatic test_async_reset();
      logic seen;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h1357_9BDF;
      bus.in_shamt  = 5'd9;
      tick();
      tick();
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL pre_reset_full got v=%b r=%b want 1/0", bus.out_valid, bus.in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      tick();
      #2;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset got spurious=%b in_ready=%b want 0/1", seen, bus.in_ready);
      end
   endtask

   task automatic test_random();
      result_t q[$];
      result_t exp_r;
      logic    exp_ready;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_arith  = 1'($urandom);
         bus.in_shamt  = 5'($urandom);
         bus.in_data   = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom | 32'h8000_0000);
         bus.in_tag    = 5'($urandom);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 31) == 0);
         #1;
         // Two ops in flight fill both stages; only a draining output frees a slot.
         exp_ready = !(q.size() == 2 && !bus.out_ready);
         checks++;
         if (bus.in_ready !== exp_ready) begin
            failures++;
            $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, exp_ready);
         end
         if (bus.out_valid && q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rand_spurious cyc=%0d got out_valid=1 want 0", cyc);
         end else if (bus.out_valid && bus.out_ready) begin
            exp_r = q.pop_front();
            checks++;
            if (bus.out_data !== exp_r.data || bus.out_tag !== exp_r.tag) begin
               failures++;
               $display("FAIL rand_result cyc=%0d got=%h/%0d want %h/%0d", cyc, bus.out_data,
                        bus.out_tag, exp_r.data, exp_r.tag);
            end
         end
         if (bus.flush) begin
            q.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            exp_r.data = ref_shift(bus.in_arith, bus.in_shamt, bus.in_data);
            exp_r.tag  = bus.in_tag;
            q.push_back(exp_r);
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      idle_inputs();
      test_reset();
      test_smoke();
      test_sign_fill();
      test_sweep();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shifter_r32_pipe.md
Name: shifter_r32_pipe

Overview:
- Two-stage pipelined 32-bit right shifter for the RV32 execute path. Implements SRL/SRLI (zero fill) and SRA/SRAI (sign fill). It is the right-shift counterpart to the left-shift datapath.
- Sits between operand issue and writeback. Uses valid/ready handshakes on both sides and carries a destination tag alongside the data.
- Internally it is a coarse byte-granular shift stage followed by a fine 0-7 bit shift stage, with a register after each.

Parameters:
- TAG_W, 5, width of the passthrough tag (rd index).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight operations.
- in_valid  input  1  operation presented.
- in_ready  output  1  shifter can accept this cycle.
- in_arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill).
- in_shamt  input  5  shift amount 0-31.
- in_data  input  32  operand.
- in_tag  input  TAG_W  passthrough tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  32  shifted result.
- out_tag  output  TAG_W  tag of result.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0, all stage registers 0. in_ready is 1 after reset.
- Accept rule: accept when in_valid & in_ready. Transfer out when out_valid & out_ready.
- Stage 1 register, captured on accept:
  - fill = in_arith & in_data[31].
  - Coarse data = in_data shifted right by 8*in_shamt[4:3], vacated bits = fill.
  - Store shamt[2:0], fill and tag.
- Stage 2 register, captured when s1 advances:
  - Data = s1 data shifted right by shamt[2:0], vacated bits = fill. This register drives out_data/out_tag. out_valid = s2_valid.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput 1 op/cycle.
- Stall rules:
  - s2_advance_ok = !s2_valid | out_ready.
  - s1 advances when s1_valid & s2_advance_ok.
  - in_ready = !s1_valid | s2_advance_ok. This is a combinational backpressure chain, with no combinational path from in_valid to in_ready.
- When stalled, stage registers hold; out_data and out_tag stay stable while out_valid=1 & !out_ready.
- Simultaneous out transfer with no s1 advance: s2_valid clears next cycle.
- Simultaneous accept and s1 advance: s1 reloads with the new op in the same cycle.
- Boundaries:
  - shamt=0 returns in_data unchanged for both SRL and SRA.
  - shamt=31 gives 0x00000001 or 0 for SRL, and all-fill for SRA.
  - SRA of a positive operand equals SRL.
- Only in_shamt[4:0] is used; the RV instruction's bit 5 is not an input.
- flush: synchronously clears s1_valid and s2_valid next edge regardless of out_ready. Data registers may keep stale values. An accept in the same cycle as flush is discarded. in_ready still follows the rule above.
- Reset asserted mid-operation: all valids drop immediately (asynchronous) and no partial result appears after release.

Test Plan:
- SRL smoke: in_data=0xF0000000, shamt=4, arith=0, out_ready=1 -> out_valid 2 cycles later, out_data=0x0F000000, tag echoed.
- SRA sign fill: in_data=0x80000000, shamt=31, arith=1 -> 0xFFFFFFFF. Same operand with arith=0 -> 0x00000001. in_data=0x7FFFFFFF, shamt=31, arith=1 -> 0x00000000.
- Coarse+fine combination: in_data=0x12345678, arith=0, shamt swept 0..31 -> each result equals in_data>>shamt. shamt=0 -> 0x12345678, shamt=13 -> 0x000091A2.
- Backpressure:
  - Stream 4 ops back-to-back with out_ready=0 from cycle 2 -> in_ready drops after 2 accepted ops, out_data stable.
  - Raise out_ready -> results emerge in order with correct tags, none lost or duplicated.
- Flush with 2 ops in flight and out_ready=0 -> out_valid=0 next cycle. A following op (0xFFFF0000 >> 8, arith=1) returns 0xFFFFFF00 2 cycles after accept.
- Async reset mid-stream: drop rst_n between clock edges with s1 and s2 valid -> out_valid=0 immediately. After release, in_ready=1 and no spurious output.
